// File: rtl/regfile_pkg.sv
// Shared definitions for the scoreboarded register file: default sizes,
// the address type and the reset-image helper.
package regfile_pkg;
  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;

  typedef logic [ADDR_W_DEF-1:0] reg_addr_t;

  // Reset value of register i in the indexed image; callers truncate to DATA_W.
  function automatic logic [63:0] init_val(input int i);
    return 64'(i) + 64'd1;
  endfunction
endpackage

// File: rtl/reg_file_sb_scoreboard.sv
// Per-register busy tracking: ready flags for both read ports, allocation
// acceptance and an incrementally maintained busy count.
module rf_scoreboard
  import regfile_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int ZERO_R0 = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] radd1,
  input  logic [ADDR_W-1:0] radd2,
  input  logic              wr,
  input  logic [ADDR_W-1:0] wadd,
  input  logic              alloc,
  input  logic [ADDR_W-1:0] alloc_add,
  output logic              rdy1,
  output logic              rdy2,
  output logic              alloc_ok,
  output logic [ADDR_W:0]   busy_cnt
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam int CW    = ADDR_W + 1;

  logic [DEPTH-1:0] busy;
  logic             z1, z2, zw, za;
  logic             wr_eff, alloc_eff, inc, dec;

  assign z1 = (ZERO_R0 != 0) && (radd1 == '0);
  assign z2 = (ZERO_R0 != 0) && (radd2 == '0);
  assign zw = (ZERO_R0 != 0) && (wadd == '0);
  assign za = (ZERO_R0 != 0) && (alloc_add == '0);

  // A write in flight this cycle satisfies any reader or allocator of that register.
  assign rdy1     = z1 | ~busy[radd1]     | (wr & (wadd == radd1));
  assign rdy2     = z2 | ~busy[radd2]     | (wr & (wadd == radd2));
  assign alloc_ok = za | ~busy[alloc_add] | (wr & (wadd == alloc_add));

  assign wr_eff    = wr & ~zw;
  assign alloc_eff = alloc & alloc_ok & ~za;

  // Same-address wr+alloc keeps the bit set, so neither side moves the count.
  assign inc = alloc_eff & ~busy[alloc_add];
  assign dec = wr_eff & busy[wadd] & ~(alloc_eff & (alloc_add == wadd));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy     <= '0;
      busy_cnt <= '0;
    end else begin
      if (wr_eff)    busy[wadd]      <= 1'b0;
      if (alloc_eff) busy[alloc_add] <= 1'b1;
      busy_cnt <= busy_cnt + CW'(inc) - CW'(dec);
    end
  end
endmodule

// File: rtl/reg_file_sb.sv
// Register file with async reset image, same-cycle write bypass, optional
// hardwired-zero r0 and a busy scoreboard for pending writebacks.
module reg_file_sb
  import regfile_pkg::*;
#(
  parameter int DATA_W        = DATA_W_DEF,
  parameter int ADDR_W        = ADDR_W_DEF,
  parameter int RESET_INDEXED = 1,
  parameter int ZERO_R0       = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] radd1,
  input  logic [ADDR_W-1:0] radd2,
  output logic [DATA_W-1:0] dataout1,
  output logic [DATA_W-1:0] dataout2,
  output logic              rdy1,
  output logic              rdy2,
  input  logic              wr,
  input  logic [ADDR_W-1:0] wadd,
  input  logic [DATA_W-1:0] datain,
  input  logic              alloc,
  input  logic [ADDR_W-1:0] alloc_add,
  output logic              alloc_ok,
  output logic [ADDR_W:0]   busy_cnt
);
  localparam int DEPTH = 1 << ADDR_W;

  logic [DEPTH-1:0][DATA_W-1:0] regs;
  logic                         wr_eff;

  assign wr_eff = wr & ~((ZERO_R0 != 0) && (wadd == '0));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++)
        regs[i] <= (RESET_INDEXED != 0) ? DATA_W'(init_val(i)) : '0;
    end else if (wr_eff) begin
      regs[wadd] <= datain;
    end
  end

  // Zero register wins over bypass; bypass wins over stored data.
  always_comb begin
    dataout1 = regs[radd1];
    dataout2 = regs[radd2];
    if (wr && wadd == radd1) dataout1 = datain;
    if (wr && wadd == radd2) dataout2 = datain;
    if ((ZERO_R0 != 0) && radd1 == '0) dataout1 = '0;
    if ((ZERO_R0 != 0) && radd2 == '0) dataout2 = '0;
  end

  rf_scoreboard #(.ADDR_W(ADDR_W), .ZERO_R0(ZERO_R0)) u_sb (
    .clk       (clk),
    .rst       (rst),
    .radd1     (radd1),
    .radd2     (radd2),
    .wr        (wr),
    .wadd      (wadd),
    .alloc     (alloc),
    .alloc_add (alloc_add),
    .rdy1      (rdy1),
    .rdy2      (rdy2),
    .alloc_ok  (alloc_ok),
    .busy_cnt  (busy_cnt)
  );
endmodule
